// File: rtl/dpsram_rd_seq.sv
// Burst read sequencer: issues SRAM port-A reads and streams the words through a 4-entry credit-managed FIFO.
// Optional stall counter output o_StallCnt is included when RDSEQ_PERF_EN is defined.
module dpsram_rd_seq #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 24
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_Start,
    input  logic [ADDR_W-1:0] i_BaseAddr,
    input  logic [ADDR_W:0]   i_Len,
    input  logic              i_Abort,
    output logic [ADDR_W-1:0] o_Addr_A,
    output logic              o_EN_R_A,
    input  logic [DATA_W-1:0] i_DataOut_A,
    output logic [DATA_W-1:0] o_Data,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic              o_Busy,
    output logic              o_Done
`ifdef RDSEQ_PERF_EN
    ,
    output logic [15:0]       o_StallCnt
`endif
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              en_q, en_n;
    logic              cap_q;
    logic [LEN_W-1:0]  iss_left_q, iss_left_n;
    logic [LEN_W-1:0]  rem_q, rem_n;
    logic              done_q, done_n;
    logic              busy_q;
    logic              valid_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_n;
    logic              pop, push, flush, start_acc;
    logic [3:0]        committed;

    // Next-state, issue credit and FIFO occupancy
    always_comb begin
        state_n    = state;
        en_n       = 1'b0;
        addr_n     = addr_q;
        iss_left_n = iss_left_q;
        rem_n      = rem_q;
        done_n     = 1'b0;
        flush      = 1'b0;
        start_acc  = 1'b0;
        pop        = valid_q & i_Ready;
        push       = cap_q;
        // words held in the FIFO, returning from SRAM, or being read this cycle
        committed  = 4'(count) + 4'(cap_q) + 4'(en_q) - 4'(pop);
        if (pop) rem_n = rem_q - LEN_W'(1);
        case (state)
            IDLE: begin
                if (i_Start && (i_Len != '0)) begin
                    start_acc  = 1'b1;
                    state_n    = (i_Len == LEN_W'(1)) ? DRAIN : RUN;
                    en_n       = 1'b1;
                    addr_n     = i_BaseAddr;
                    iss_left_n = i_Len - LEN_W'(1);
                    rem_n      = i_Len;
                end
            end
            RUN: begin
                if (i_Abort) begin
                    state_n = IDLE;
                    flush   = 1'b1;
                end else if ((iss_left_q != '0) && (committed < 4'd4)) begin
                    en_n       = 1'b1;
                    addr_n     = addr_q + ADDR_W'(1);
                    iss_left_n = iss_left_q - LEN_W'(1);
                    if (iss_left_q == LEN_W'(1)) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (i_Abort) begin
                    state_n = IDLE;
                    flush   = 1'b1;
                end else if (pop && (rem_q == LEN_W'(1))) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        count_n = flush ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
    end

    // State and control registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            addr_q     <= '0;
            en_q       <= 1'b0;
            cap_q      <= 1'b0;
            iss_left_q <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            count      <= '0;
        end else begin
            state      <= state_n;
            addr_q     <= addr_n;
            en_q       <= en_n;
            cap_q      <= en_q & ~flush;
            iss_left_q <= iss_left_n;
            rem_q      <= rem_n;
            done_q     <= done_n;
            busy_q     <= (state_n != IDLE);
            valid_q    <= (count_n != '0);
            count      <= count_n;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= i_DataOut_A;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    assign o_Addr_A = addr_q;
    assign o_EN_R_A = en_q;
    assign o_Data   = mem[rd_ptr];
    assign o_Valid  = valid_q;
    assign o_Busy   = busy_q;
    assign o_Done   = done_q;

`ifdef RDSEQ_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of cycles where valid data is held back by the consumer
    always_ff @(posedge CLK) begin
        if (RST || start_acc) begin
            stall_q <= '0;
        end else if (valid_q && !i_Ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_StallCnt = stall_q;
`endif

endmodule

// File: tb/tb_dpsram_rd_seq.sv
// Self-checking bench for dpsram_rd_seq: table of bursts plus abort, ignored-start and reset sequences.
module tb_dpsram_rd_seq;

    logic        CLK;
    logic        RST;
    logic        i_Start;
    logic [8:0]  i_BaseAddr;
    logic [9:0]  i_Len;
    logic        i_Abort;
    logic [8:0]  o_Addr_A;
    logic        o_EN_R_A;
    logic [23:0] i_DataOut_A;
    logic [23:0] o_Data;
    logic        o_Valid;
    logic        i_Ready;
    logic        o_Busy;
    logic        o_Done;
`ifdef RDSEQ_PERF_EN
    logic [15:0] o_StallCnt;
`endif

    dpsram_rd_seq #(.ADDR_W(9), .DATA_W(24)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_Start     (i_Start),
        .i_BaseAddr  (i_BaseAddr),
        .i_Len       (i_Len),
        .i_Abort     (i_Abort),
        .o_Addr_A    (o_Addr_A),
        .o_EN_R_A    (o_EN_R_A),
        .i_DataOut_A (i_DataOut_A),
        .o_Data      (o_Data),
        .o_Valid     (o_Valid),
        .i_Ready     (i_Ready),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done)
`ifdef RDSEQ_PERF_EN
        ,
        .o_StallCnt  (o_StallCnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [23:0] word_of(input logic [8:0] a);
        return 24'(({15'd0, a} * 24'd197) ^ 24'h5A5000);
    endfunction

    // SRAM port A: data valid the cycle after the enabling edge
    logic [23:0] sram_q;
    initial sram_q = '0;
    always @(posedge CLK) if (o_EN_R_A) sram_q <= word_of(o_Addr_A);
    assign i_DataOut_A = sram_q;

    typedef struct {
        logic [8:0] base;
        logic [9:0] len;
        int         mode;      // 1: ready high, 2: ready toggles, 3: ready random
        int         exp_done;  // expected o_Done cycle after start edge, 0 = not fixed
        bit         poke;      // extra i_Start while busy
        bit         abs;       // i_Abort together with i_Start
    } vec_t;

    vec_t        tbl [9];
    logic [23:0] sb [$];
    int          ntotal = 0;
    int          npass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Entered and left #1 after a rising edge
    task automatic run_burst(input int idx);
        vec_t        v;
        logic [8:0]  exp_addr;
        logic [23:0] prev_data, w;
        int          issued, accepted, first_lat, done_seen, done_lat, max_out, stalls, outst;
        bit          prev_hold, r;
        v = tbl[idx];
        sb.delete();
        for (int i = 0; i < int'(v.len); i++) sb.push_back(word_of(9'(int'(v.base) + i)));
        exp_addr = v.base;
        issued = 0; accepted = 0; first_lat = -1; done_seen = 0; done_lat = -1;
        max_out = 0; stalls = 0; prev_hold = 1'b0; prev_data = '0;
        i_Start = 1'b1; i_BaseAddr = v.base; i_Len = v.len; i_Abort = v.abs; i_Ready = 1'b0;
        for (int n = 1; n < 4 * int'(v.len) + 40 && done_seen == 0; n++) begin
            @(posedge CLK); #1;
            if (n == 1) begin i_Start = 1'b0; i_Abort = 1'b0; end
            if (v.poke && n == 2) begin
                i_Start = 1'b1; i_BaseAddr = 9'h100; i_Len = 10'd5;
            end
            if (v.poke && n == 3) i_Start = 1'b0;
            if (o_EN_R_A) begin
                chk("issue_addr", 32'(o_Addr_A), 32'(exp_addr));
                exp_addr = exp_addr + 9'd1;
                issued++;
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(o_Valid), 32'd1);
                chk("hold_data", 32'(o_Data), 32'(prev_data));
            end
            if (o_Valid && first_lat < 0) first_lat = n;
            if (o_Done) begin
                done_seen++;
                done_lat = n;
                chk("busy_at_done", 32'(o_Busy), 32'd0);
            end
            case (v.mode)
                1:       r = 1'b1;
                2:       r = (n % 2) == 1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            i_Ready = r;
            outst = issued - accepted;
            if (outst > max_out) max_out = outst;
            if (o_Valid && r) begin
                if (sb.size() == 0) begin
                    chk("extra_word", 32'(o_Data), 32'hFFFF_FFFF);
                end else begin
                    w = sb.pop_front();
                    chk("word_data", 32'(o_Data), 32'(w));
                end
                accepted++;
            end
            if (o_Valid && !r) stalls++;
            prev_hold = o_Valid && !r;
            prev_data = o_Data;
        end
        i_Ready = 1'b0;
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("issued_count", 32'(issued), 32'(v.len));
        chk("accepted_count", 32'(accepted), 32'(v.len));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("first_valid_lat", 32'(first_lat), 32'd3);
        chk("max_outstanding_le4", 32'(max_out <= 4), 32'd1);
        if (v.exp_done != 0) chk("done_latency", 32'(done_lat), 32'(v.exp_done));
`ifdef RDSEQ_PERF_EN
        chk("stall_cnt", 32'(o_StallCnt), 32'(stalls));
`endif
        @(posedge CLK); #1;
        chk("done_one_cycle", 32'(o_Done), 32'd0);
    endtask

    initial begin
        tbl[0] = '{base: 9'h010, len: 10'd8,   mode: 1, exp_done: 11,  poke: 1'b0, abs: 1'b0};
        tbl[1] = '{base: 9'h1FE, len: 10'd4,   mode: 1, exp_done: 7,   poke: 1'b0, abs: 1'b0};
        tbl[2] = '{base: 9'h000, len: 10'd16,  mode: 2, exp_done: 0,   poke: 1'b0, abs: 1'b0};
        tbl[3] = '{base: 9'h0A0, len: 10'd1,   mode: 1, exp_done: 4,   poke: 1'b0, abs: 1'b0};
        tbl[4] = '{base: 9'h123, len: 10'd512, mode: 1, exp_done: 515, poke: 1'b0, abs: 1'b0};
        tbl[5] = '{base: 9'h050, len: 10'd6,   mode: 1, exp_done: 9,   poke: 1'b1, abs: 1'b0};
        tbl[6] = '{base: 9'h070, len: 10'd5,   mode: 1, exp_done: 8,   poke: 1'b0, abs: 1'b1};
        tbl[7] = '{base: 9'h1F0, len: 10'd20,  mode: 3, exp_done: 0,   poke: 1'b0, abs: 1'b0};
        tbl[8] = '{base: 9'h000, len: 10'd2,   mode: 1, exp_done: 5,   poke: 1'b0, abs: 1'b0};

        RST = 1'b1; i_Start = 1'b0; i_BaseAddr = '0; i_Len = '0; i_Abort = 1'b0; i_Ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_en", 32'(o_EN_R_A), 32'd0);
        chk("rst_addr", 32'(o_Addr_A), 32'd0);
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_done", 32'(o_Done), 32'd0);
        chk("rst_busy", 32'(o_Busy), 32'd0);
        chk("rst_data", 32'(o_Data), 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Zero-length start must be ignored
        i_Start = 1'b1; i_BaseAddr = 9'h005; i_Len = 10'd0;
        for (int n = 0; n < 4; n++) begin
            @(posedge CLK); #1;
            i_Start = 1'b0;
            chk("len0_en", 32'(o_EN_R_A), 32'd0);
            chk("len0_busy", 32'(o_Busy), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            run_burst(i);
            @(posedge CLK); #1;
        end

        // Abort after three accepted words
        begin
            int acc;
            acc = 0;
            sb.delete();
            for (int i = 0; i < 10; i++) sb.push_back(word_of(9'(9'h040 + i)));
            i_Start = 1'b1; i_BaseAddr = 9'h040; i_Len = 10'd10; i_Ready = 1'b1;
            for (int n = 1; n < 40 && acc < 3; n++) begin
                @(posedge CLK); #1;
                i_Start = 1'b0;
                if (o_Valid) begin
                    chk("abort_pre_data", 32'(o_Data), 32'(sb.pop_front()));
                    acc++;
                end
            end
            chk("abort_pre_count", 32'(acc), 32'd3);
            @(posedge CLK); #1;
            i_Abort = 1'b1; i_Ready = 1'b0;
            @(posedge CLK); #1;
            i_Abort = 1'b0;
            chk("abort_valid", 32'(o_Valid), 32'd0);
            chk("abort_busy", 32'(o_Busy), 32'd0);
            chk("abort_en", 32'(o_EN_R_A), 32'd0);
            chk("abort_done", 32'(o_Done), 32'd0);
            for (int n = 0; n < 5; n++) begin
                @(posedge CLK); #1;
                chk("abort_quiet", 32'({o_Valid, o_Done, o_Busy}), 32'd0);
            end
            sb.delete();
        end
        run_burst(8);
        @(posedge CLK); #1;

        // Reset mid-burst with the consumer stalled
        i_Start = 1'b1; i_BaseAddr = 9'h080; i_Len = 10'd12; i_Ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(posedge CLK); #1;
            i_Start = 1'b0;
        end
        chk("pre_rst_valid", 32'(o_Valid), 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("mid_rst_en", 32'(o_EN_R_A), 32'd0);
        chk("mid_rst_addr", 32'(o_Addr_A), 32'd0);
        chk("mid_rst_valid", 32'(o_Valid), 32'd0);
        chk("mid_rst_done", 32'(o_Done), 32'd0);
        chk("mid_rst_busy", 32'(o_Busy), 32'd0);
        chk("mid_rst_data", 32'(o_Data), 32'd0);
        for (int n = 0; n < 6; n++) begin
            @(posedge CLK); #1;
            chk("post_rst_quiet", 32'({o_Valid, o_EN_R_A, o_Done}), 32'd0);
        end

        run_burst(0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/dpsram_rd_seq.md
DPSRAM_RD_SEQ -- requirements
Module: dpsram_rd_seq

Interface
REQ-001 Parameter ADDR_W, default 9, SRAM address width (512 words).
REQ-002 Parameter DATA_W, default 24, SRAM word width.
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 i_Start  input  1  launch a burst; sampled only in IDLE.
REQ-006 i_BaseAddr  input  ADDR_W  first word address; sampled with i_Start.
REQ-007 i_Len  input  ADDR_W+1  word count, 1..512; sampled with i_Start.
REQ-008 i_Abort  input  1  terminate the active burst.
REQ-009 o_Addr_A  output  ADDR_W  SRAM port-A address, registered.
REQ-010 o_EN_R_A  output  1  SRAM port-A read enable, registered, active-high.
REQ-011 i_DataOut_A  input  DATA_W  SRAM port-A read data, valid the cycle after the enabling edge.
REQ-012 o_Data  output  DATA_W  stream data; equals FIFO head.
REQ-013 o_Valid  output  1  stream data valid.
REQ-014 i_Ready  input  1  downstream accepts; a transfer occurs when o_Valid and i_Ready are both high.
REQ-015 o_Busy  output  1  high in any state other than IDLE.
REQ-016 o_Done  output  1  one-cycle pulse when the burst completes.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-018 IDLE->RUN when i_Start=1 and i_Len!=0; i_Start with i_Len=0 SHALL be ignored; i_Start outside IDLE SHALL be ignored.
REQ-019 RUN: o_EN_R_A=1 in each cycle where words issued < Len and (FIFO occupancy + reads in flight) < 4; otherwise o_EN_R_A=0.
REQ-020 Issued addresses SHALL be BaseAddr, BaseAddr+1, ... modulo 2^ADDR_W (511 wraps to 0).
REQ-021 Read data SHALL be captured into a 4-entry FIFO on the edge after the SRAM data becomes valid; the block SHALL never drop or duplicate a word.
REQ-022 First-word latency: i_Start sampled at edge k -> o_EN_R_A high in cycle k+1 -> o_Valid high in cycle k+3.
REQ-023 With i_Ready held high, throughput SHALL be 1 word per cycle after the first word.
REQ-024 i_Ready=0 SHALL hold o_Data and o_Valid stable; issue SHALL stall by credit and no FIFO overflow is permitted.
REQ-025 RUN->DRAIN when the last read is issued; DRAIN->IDLE on acceptance of the last word, with o_Done=1 for exactly one cycle on the following cycle.
REQ-026 FIFO push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-027 i_Abort in RUN or DRAIN SHALL, on the next edge: go to IDLE, flush the FIFO, discard in-flight data, deassert o_EN_R_A and o_Valid, and produce no o_Done.
REQ-028 i_Abort in IDLE SHALL have no effect; i_Abort with i_Start in IDLE SHALL give i_Start priority.

Reset
REQ-029 On RST: state=IDLE, FIFO empty, in-flight tracking cleared; o_EN_R_A=0, o_Addr_A=0, o_Valid=0, o_Done=0, o_Busy=0, o_Data=0.
REQ-030 RST asserted mid-burst SHALL abort as in REQ-027, and any SRAM data returning after reset SHALL be ignored.

Configuration
REQ-031 When macro RDSEQ_PERF_EN is defined, the block SHALL add output o_StallCnt (16 bits): it counts cycles with o_Valid=1 and i_Ready=0, saturates at 0xFFFF, and clears on RST and on an accepted i_Start.
REQ-032 When RDSEQ_PERF_EN is not defined, o_StallCnt and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Base=0x010, Len=8, i_Ready=1 -> addresses 0x010..0x017 on consecutive cycles, first o_Valid at cycle k+3, 8 words in order, o_Done 1 cycle after the 8th.
REQ-034 Base=0x1FE, Len=4 -> addresses 0x1FE, 0x1FF, 0x000, 0x001.
REQ-035 Len=16, i_Ready toggles 1/0 each cycle -> all 16 words delivered in order, in-flight + occupancy never exceeds 4, with PERF enabled o_StallCnt=number of stalled valid cycles.
REQ-036 Abort after 3 words accepted, Len=10 -> next cycle o_Valid=0, o_Busy=0, no o_Done; a new Start (Base=0, Len=2) then works normally.
REQ-037 Start with Len=0, and Start while busy -> both ignored, with no SRAM access and no state change.
REQ-038 RST asserted mid-burst with i_Ready=0 -> all outputs reach reset values on the next cycle, and late SRAM data never appears on o_Valid.
